param_read_sched: RTL and testbench
===================================

PARAM_READ_SCHED -- requirements
Module: param_read_sched

Interface
REQ-001 Parameter NUM_CH, default 2: number of read channels, legal 1..8.
REQ-002 Parameter MAX_WORDS, default 4: maximum words per channel burst, legal 1..8.
REQ-003 Parameter INTERVAL[NUM_CH], default {100, 1000000}: cycles between automatic refreshes per channel, legal >=2.
REQ-004 Parameter BASE_ADDR[NUM_CH], default {8'h00, 8'h04}: first bus address per channel.
REQ-005 Parameter NUM_WORDS[NUM_CH], default {1, 3}: burst length per channel, legal 1..MAX_WORDS, BASE_ADDR+NUM_WORDS-1 <= 8'hFF.
REQ-006 Parameter TIMEOUT, default 255: maximum cycles valid may wait for ready, legal 1..65535.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rstn  input  1  reset, asynchronous, active-low.
REQ-009 r_m  r_busif.master  addr[7:0]/valid out, data[31:0]/ready in  parameter bus read port.
REQ-010 enable  input  1  when high, new bursts may be granted.
REQ-011 refresh  input  NUM_CH  per-channel pulse requesting an immediate read.
REQ-012 param  output  NUM_CH x MAX_WORDS x 32  committed parameter words; unused words read 0.
REQ-013 upd  output  NUM_CH  one-cycle pulse on the cycle a channel's words are committed.
REQ-014 err  output  NUM_CH  sticky per-channel timeout flag.
REQ-015 err_clr  input  NUM_CH  clears the matching err bit; ignored if a timeout sets it in the same cycle.

Function
REQ-016 Each channel SHALL have a free-running interval counter; it counts while the channel is neither pending nor bursting, and sets pending and clears on reaching INTERVAL-1.
REQ-017 A refresh pulse SHALL set pending immediately; a coincident expiry and refresh SHALL produce one pending request.
REQ-018 A request arising while the channel is bursting SHALL stay latched and be served after the current burst.
REQ-019 The FSM SHALL have states IDLE, REQ, COMMIT; IDLE->REQ when enable=1 and any channel is pending.
REQ-020 Arbitration SHALL be round-robin: search starts at the channel after the last granted one; after reset channel 0 has highest priority.
REQ-021 On grant, the channel's pending SHALL clear, word index SHALL be 0, and valid SHALL rise with addr=BASE_ADDR on the next cycle.
REQ-022 A transfer SHALL complete on a cycle with valid=1 and ready=1; data SHALL be captured into a staging buffer on that edge.
REQ-023 Within a burst, valid SHALL stay high and addr SHALL advance by 1 on each completed transfer; after the last word valid SHALL fall on the following cycle.
REQ-024 COMMIT SHALL copy all staged words into param atomically, pulse upd for one cycle, then return to IDLE; partial bursts SHALL never reach param.
REQ-025 The timeout counter SHALL count cycles of valid=1 with ready=0 and clear on each completed transfer; on reaching TIMEOUT, valid SHALL drop, staging SHALL be discarded, err SHALL set, and the FSM SHALL return to IDLE without upd.
REQ-026 Deasserting enable SHALL block new grants only; an active burst SHALL complete or time out.
REQ-027 Minimum gap between consecutive bursts SHALL be one IDLE cycle; back-to-back pending channels SHALL be served without extra idle cycles.

Reset
REQ-028 While rstn=0: valid=0, addr=0, param all 0, upd=0, err=0, pending all 0, interval counters 0, round-robin pointer selects channel 0 first, FSM in IDLE.
REQ-029 Reset asserted mid-burst SHALL abort immediately with valid=0 and no commit; interval counting SHALL restart from 0 after release.

Structure
REQ-030 Package param_read_pkg SHALL hold the FSM state typedef, MAX_CH=8, and the bus address/data widths.
REQ-031 The per-channel interval counter with pending latch SHALL be sub-module param_interval_tmr, instantiated NUM_CH times.

Verification
REQ-032 Defaults, ready tied high: ch0 bursts every 100 cycles at addr 0x00; ch1 at cycle 1000000 reads 0x04,0x05,0x06 back-to-back, one upd[1] pulse.
REQ-033 refresh=2'b11 in the same cycle: grant order ch0 then ch1; next simultaneous request grants ch1 first.
REQ-034 ch1 burst with ready low for 2 cycles on word 1: param[1] unchanged until all 3 words complete, then all 3 words update in one cycle.
REQ-035 ready held low 255 cycles: valid drops at cycle 255, err[0]=1, param[0] unchanged, no upd; err_clr[0] clears it.
REQ-036 enable=0 while refresh[0] pulses: no valid; enable=1 later -> burst starts within 2 cycles.
REQ-037 rstn pulsed low during ch1 word 2: valid=0 and param=0 asynchronously, no upd after release.

Source files
------------

// File: rtl/param_read_pkg.sv
// Shared types and widths for the parameter read scheduler.
package param_read_pkg;
  localparam int MAX_CH = 8;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COMMIT
  } state_t;
endpackage

// File: rtl/r_busif.sv
// Simple read bus: master drives addr/valid, slave returns data/ready.
interface r_busif;
  logic [param_read_pkg::ADDR_W-1:0] addr;
  logic                              valid;
  logic [param_read_pkg::DATA_W-1:0] data;
  logic                              ready;

  modport master(output addr, valid, input data, ready);
  modport slave(input addr, valid, output data, ready);
endinterface

// File: rtl/param_interval_tmr.sv
// Purpose: per-channel refresh interval counter with a latched pending request.
// Latency: pending rises one cycle after expiry or a refresh pulse.
// Backpressure: counter holds while the request is pending or the channel is bursting.
module param_interval_tmr #(
  parameter int unsigned INTERVAL = 100
) (
  input  logic clk,
  input  logic rstn,
  input  logic refresh,
  input  logic grant,
  input  logic busy,
  output logic pending
);
  localparam int W = $clog2(INTERVAL);
  localparam logic [W-1:0] LAST = W'(INTERVAL - 1);

  logic [W-1:0] cnt;
  logic         run;
  logic         expire;

  assign run    = !pending && !busy;
  assign expire = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      if (run) cnt <= expire ? '0 : cnt + 1'b1;
      // a new request on the grant cycle stays latched for the next round
      pending <= refresh | expire | (pending & ~grant);
    end
  end
endmodule

// File: rtl/param_read_sched.sv
// Purpose: round-robin scheduler reading per-channel parameter bursts and committing them atomically.
// Latency: valid rises one cycle after grant; param/upd update one cycle after the last word.
// Backpressure: valid holds while ready is low, aborting with err after TIMEOUT stalled cycles.
module param_read_sched
  import param_read_pkg::*;
#(
  parameter int                              NUM_CH    = 2,
  parameter int                              MAX_WORDS = 4,
  parameter logic [NUM_CH-1:0][31:0]         INTERVAL  = {32'd1000000, 32'd100},
  parameter logic [NUM_CH-1:0][ADDR_W-1:0]   BASE_ADDR = {8'h04, 8'h00},
  parameter logic [NUM_CH-1:0][3:0]          NUM_WORDS = {4'd3, 4'd1},
  parameter int                              TIMEOUT   = 255
) (
  input  logic                                        clk,
  input  logic                                        rstn,
  r_busif.master                                      r_m,
  input  logic                                        enable,
  input  logic [NUM_CH-1:0]                           refresh,
  output logic [NUM_CH-1:0][MAX_WORDS-1:0][DATA_W-1:0] param,
  output logic [NUM_CH-1:0]                           upd,
  output logic [NUM_CH-1:0]                           err,
  input  logic [NUM_CH-1:0]                           err_clr
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  state_t                           state, state_nxt;
  logic [CW-1:0]                    cur_ch, last_ch, sel_ch, cand;
  logic [WW-1:0]                    widx;
  logic [15:0]                      tcnt;
  logic [MAX_WORDS-1:0][DATA_W-1:0] stage;
  logic [NUM_CH-1:0]                pending, grant_vec, busy_vec;
  logic                             any_pend, grant_go, xfer, last_word, tmo;

  assign xfer      = r_m.valid && r_m.ready;
  assign last_word = (4'(widx) == NUM_WORDS[cur_ch] - 4'd1);
  assign tmo       = r_m.valid && !r_m.ready && (tcnt == 16'(TIMEOUT - 1));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_tmr
    param_interval_tmr #(.INTERVAL(INTERVAL[i])) u_tmr (
      .clk    (clk),
      .rstn   (rstn),
      .refresh(refresh[i]),
      .grant  (grant_vec[i]),
      .busy   (busy_vec[i]),
      .pending(pending[i])
    );
  end

  // walk downward so the channel nearest after last_ch wins
  always_comb begin
    sel_ch   = '0;
    cand     = '0;
    any_pend = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = CW'((int'(last_ch) + k) % NUM_CH);
      if (pending[cand]) begin
        sel_ch   = cand;
        any_pend = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_go  = 1'b0;
    case (state)
      IDLE:    if (enable && any_pend) begin
                 grant_go  = 1'b1;
                 state_nxt = REQ;
               end
      REQ:     if (tmo) state_nxt = IDLE;
               else if (xfer && last_word) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_vec         = '0;
    busy_vec          = '0;
    grant_vec[sel_ch] = grant_go;
    busy_vec[cur_ch]  = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_m.valid <= 1'b0;
      r_m.addr  <= '0;
      cur_ch    <= '0;
      last_ch   <= CW'(NUM_CH - 1);
      widx      <= '0;
      tcnt      <= '0;
      stage     <= '0;
      param     <= '0;
      upd       <= '0;
      err       <= '0;
    end else begin
      upd <= '0;
      err <= err & ~err_clr;
      case (state)
        IDLE: if (grant_go) begin
          cur_ch    <= sel_ch;
          last_ch   <= sel_ch;
          widx      <= '0;
          tcnt      <= '0;
          stage     <= '0;
          r_m.valid <= 1'b1;
          r_m.addr  <= BASE_ADDR[sel_ch];
        end
        REQ: begin
          if (xfer) begin
            stage[widx] <= r_m.data;
            tcnt        <= '0;
            if (last_word) begin
              r_m.valid <= 1'b0;
            end else begin
              widx     <= widx + 1'b1;
              r_m.addr <= r_m.addr + 1'b1;
            end
          end else if (tmo) begin
            r_m.valid   <= 1'b0;
            err[cur_ch] <= 1'b1;
          end else if (r_m.valid) begin
            tcnt <= tcnt + 16'd1;
          end
        end
        COMMIT: begin
          param[cur_ch] <= stage;
          upd[cur_ch]   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_param_read_sched.sv
// Directed bench for param_read_sched with default parameters; bus data = {salt, addr}.
module tb_param_read_sched;
  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   enable;
  logic [1:0]             refresh;
  logic [1:0][3:0][31:0]  param;
  logic [1:0]             upd;
  logic [1:0]             err;
  logic [1:0]             err_clr;
  logic                   rdy;
  logic [23:0]            salt;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int vld_hi   = 0;
  int upd_cnt [2];
  int rise_cyc [$];
  logic [7:0] rise_addr [$];
  logic [7:0] xq [$];
  logic vq = 1'b0;

  r_busif bus();
  assign bus.data  = {salt, bus.addr};
  assign bus.ready = rdy;

  param_read_sched dut (
    .clk    (clk),
    .rstn   (rstn),
    .r_m    (bus),
    .enable (enable),
    .refresh(refresh),
    .param  (param),
    .upd    (upd),
    .err    (err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rstn && bus.valid && bus.ready) xq.push_back(bus.addr);
  end

  always @(negedge clk) begin
    if (bus.valid && !vq) begin
      rise_cyc.push_back(cyc);
      rise_addr.push_back(bus.addr);
    end
    vq = bus.valid;
    if (bus.valid) vld_hi++;
    for (int i = 0; i < 2; i++) if (upd[i]) upd_cnt[i]++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rise_cyc.delete();
    rise_addr.delete();
    xq.delete();
    vld_hi     = 0;
    upd_cnt[0] = 0;
    upd_cnt[1] = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; refresh = '0; err_clr = '0; rdy = 1'b1; enable = 1'b1;
    tick(2);
    rstn = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    rstn = 1'b0; refresh = '0; err_clr = '0; rdy = 1'b1; enable = 1'b1; salt = '0;
    tick(2);
    chk_cnt++; if (bus.valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.valid); else pass_cnt++;
    chk_cnt++; if (bus.addr !== 8'h00) $display("FAIL rst_addr: got %h want 00", bus.addr); else pass_cnt++;
    chk_cnt++; if (param !== '0) $display("FAIL rst_param: got %h want 0", param); else pass_cnt++;
    chk_cnt++; if (upd !== 2'b00) $display("FAIL rst_upd: got %b want 00", upd); else pass_cnt++;
    chk_cnt++; if (err !== 2'b00) $display("FAIL rst_err: got %b want 00", err); else pass_cnt++;
    rstn = 1'b1;
    clear_logs();
    tick(20);
    chk_cnt++; if (rise_cyc.size() !== 0) $display("FAIL rst_no_pending: got %0d bursts want 0", rise_cyc.size()); else pass_cnt++;
  endtask

  task automatic test_periodic();
    int c0, r0, r1;
    logic [7:0] a0;
    do_reset();
    salt = 24'hC0FFEE;
    c0 = cyc;
    tick(210);
    r0 = (rise_cyc.size() > 0) ? rise_cyc[0] - c0 : -1;
    r1 = (rise_cyc.size() > 1) ? rise_cyc[1] - c0 : -1;
    a0 = (rise_addr.size() > 0) ? rise_addr[0] : 8'hxx;
    chk_cnt++; if (rise_cyc.size() !== 2) $display("FAIL per_count: got %0d want 2", rise_cyc.size()); else pass_cnt++;
    chk_cnt++; if (r0 !== 101) $display("FAIL per_first: got %0d want 101", r0); else pass_cnt++;
    chk_cnt++; if (r1 !== 204) $display("FAIL per_second: got %0d want 204", r1); else pass_cnt++;
    chk_cnt++; if (a0 !== 8'h00) $display("FAIL per_addr: got %h want 00", a0); else pass_cnt++;
    chk_cnt++; if (upd_cnt[0] !== 2) $display("FAIL per_upd0: got %0d want 2", upd_cnt[0]); else pass_cnt++;
    chk_cnt++; if (upd_cnt[1] !== 0) $display("FAIL per_upd1: got %0d want 0", upd_cnt[1]); else pass_cnt++;
    chk_cnt++; if (param[0][0] !== {24'hC0FFEE, 8'h00}) $display("FAIL per_word0: got %h want %h", param[0][0], {24'hC0FFEE, 8'h00}); else pass_cnt++;
    chk_cnt++; if (param[0][1] !== 32'h0) $display("FAIL per_unused: got %h want 0", param[0][1]); else pass_cnt++;
  endtask

  task automatic test_ch1_burst();
    logic [7:0] x0, x1, x2;
    do_reset();
    salt = 24'h1A2B3C;
    refresh = 2'b10; tick(1); refresh = '0;
    tick(12);
    x0 = (xq.size() > 0) ? xq[0] : 8'hxx;
    x1 = (xq.size() > 1) ? xq[1] : 8'hxx;
    x2 = (xq.size() > 2) ? xq[2] : 8'hxx;
    chk_cnt++; if (rise_cyc.size() !== 1) $display("FAIL ch1_rises: got %0d want 1", rise_cyc.size()); else pass_cnt++;
    chk_cnt++; if (xq.size() !== 3) $display("FAIL ch1_xfers: got %0d want 3", xq.size()); else pass_cnt++;
    chk_cnt++; if ({x0, x1, x2} !== 24'h040506) $display("FAIL ch1_addrs: got %h want 040506", {x0, x1, x2}); else pass_cnt++;
    chk_cnt++; if (vld_hi !== 3) $display("FAIL ch1_valid_cycles: got %0d want 3", vld_hi); else pass_cnt++;
    chk_cnt++; if (upd_cnt[1] !== 1) $display("FAIL ch1_upd: got %0d want 1", upd_cnt[1]); else pass_cnt++;
    chk_cnt++; if (param[1] !== {32'h0, 24'h1A2B3C, 8'h06, 24'h1A2B3C, 8'h05, 24'h1A2B3C, 8'h04})
      $display("FAIL ch1_param: got %h want %h", param[1], {32'h0, 24'h1A2B3C, 8'h06, 24'h1A2B3C, 8'h05, 24'h1A2B3C, 8'h04}); else pass_cnt++;
    chk_cnt++; if (param[0] !== '0) $display("FAIL ch1_ch0_untouched: got %h want 0", param[0]); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [7:0] a0, a1, a2;
    int g01, g12;
    do_reset();
    salt = 24'h00BEEF;
    refresh = 2'b11; tick(1); refresh = '0;
    tick(1);
    refresh = 2'b11; tick(1); refresh = '0;
    tick(20);
    a0 = (rise_addr.size() > 0) ? rise_addr[0] : 8'hxx;
    a1 = (rise_addr.size() > 1) ? rise_addr[1] : 8'hxx;
    a2 = (rise_addr.size() > 2) ? rise_addr[2] : 8'hxx;
    g01 = (rise_cyc.size() > 1) ? rise_cyc[1] - rise_cyc[0] : -1;
    g12 = (rise_cyc.size() > 2) ? rise_cyc[2] - rise_cyc[1] : -1;
    chk_cnt++; if (rise_cyc.size() !== 3) $display("FAIL rr_count: got %0d want 3", rise_cyc.size()); else pass_cnt++;
    chk_cnt++; if ({a0, a1, a2} !== 24'h000400) $display("FAIL rr_order: got %h want 000400", {a0, a1, a2}); else pass_cnt++;
    chk_cnt++; if (g01 !== 3) $display("FAIL rr_gap01: got %0d want 3", g01); else pass_cnt++;
    chk_cnt++; if (g12 !== 5) $display("FAIL rr_gap12: got %0d want 5", g12); else pass_cnt++;
    chk_cnt++; if (upd_cnt[0] !== 2 || upd_cnt[1] !== 1) $display("FAIL rr_upd: got %0d/%0d want 2/1", upd_cnt[0], upd_cnt[1]); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int n;
    logic early;
    logic [127:0] a_vec, b_vec;
    a_vec = {32'h0, 24'h111111, 8'h06, 24'h111111, 8'h05, 24'h111111, 8'h04};
    b_vec = {32'h0, 24'h222222, 8'h06, 24'h222222, 8'h05, 24'h222222, 8'h04};
    do_reset();
    salt = 24'h111111;
    refresh = 2'b10; tick(1); refresh = '0;
    tick(10);
    chk_cnt++; if (param[1] !== a_vec) $display("FAIL bp_setup: got %h want %h", param[1], a_vec); else pass_cnt++;
    salt = 24'h222222;
    refresh = 2'b10; tick(1); refresh = '0;
    n = 0;
    while (!(bus.valid && bus.addr == 8'h05) && n < 20) begin tick(1); n++; end
    chk_cnt++; if (n >= 20) $display("FAIL bp_word1_wait: got %0d cycles want <20", n); else pass_cnt++;
    rdy = 1'b0;
    tick(1);
    chk_cnt++; if (param[1] !== a_vec) $display("FAIL bp_stall1: got %h want %h", param[1], a_vec); else pass_cnt++;
    tick(1);
    chk_cnt++; if (bus.valid !== 1'b1 || bus.addr !== 8'h05) $display("FAIL bp_hold: got %b/%h want 1/05", bus.valid, bus.addr); else pass_cnt++;
    rdy = 1'b1;
    n = 0; early = 1'b0;
    while (!upd[1] && n < 10) begin
      if (param[1] !== a_vec) early = 1'b1;
      tick(1); n++;
    end
    chk_cnt++; if (early !== 1'b0) $display("FAIL bp_partial: got %b want 0", early); else pass_cnt++;
    chk_cnt++; if (upd[1] !== 1'b1) $display("FAIL bp_upd: got %b want 1", upd[1]); else pass_cnt++;
    chk_cnt++; if (param[1] !== b_vec) $display("FAIL bp_commit: got %h want %h", param[1], b_vec); else pass_cnt++;
    tick(1);
    chk_cnt++; if (upd_cnt[1] !== 2) $display("FAIL bp_upd_count: got %0d want 2", upd_cnt[1]); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n, hi;
    do_reset();
    salt = 24'h333333;
    refresh = 2'b01; tick(1); refresh = '0;
    tick(6);
    salt = 24'h444444;
    rdy = 1'b0;
    refresh = 2'b01; tick(1); refresh = '0;
    n = 0;
    while (!bus.valid && n < 5) begin tick(1); n++; end
    hi = 0;
    while (bus.valid && hi < 400) begin hi++; tick(1); end
    chk_cnt++; if (hi !== 255) $display("FAIL to_valid_cycles: got %0d want 255", hi); else pass_cnt++;
    chk_cnt++; if (err !== 2'b01) $display("FAIL to_err: got %b want 01", err); else pass_cnt++;
    chk_cnt++; if (param[0][0] !== {24'h333333, 8'h00}) $display("FAIL to_param: got %h want %h", param[0][0], {24'h333333, 8'h00}); else pass_cnt++;
    chk_cnt++; if (upd_cnt[0] !== 1) $display("FAIL to_no_upd: got %0d want 1", upd_cnt[0]); else pass_cnt++;
    rdy = 1'b1;
    tick(3);
    chk_cnt++; if (err !== 2'b01) $display("FAIL to_sticky: got %b want 01", err); else pass_cnt++;
    err_clr = 2'b01; tick(1); err_clr = '0;
    chk_cnt++; if (err !== 2'b00) $display("FAIL to_clear: got %b want 00", err); else pass_cnt++;
  endtask

  task automatic test_enable();
    int n;
    do_reset();
    salt = 24'h00E0E0;
    enable = 1'b0;
    refresh = 2'b01; tick(1); refresh = '0;
    tick(10);
    chk_cnt++; if (rise_cyc.size() !== 0) $display("FAIL en_blocked: got %0d bursts want 0", rise_cyc.size()); else pass_cnt++;
    enable = 1'b1;
    n = 0;
    while (!bus.valid && n < 10) begin tick(1); n++; end
    chk_cnt++; if (n !== 1) $display("FAIL en_latency: got %0d want 1", n); else pass_cnt++;
    chk_cnt++; if (bus.addr !== 8'h00) $display("FAIL en_addr: got %h want 00", bus.addr); else pass_cnt++;
    tick(5);
    chk_cnt++; if (upd_cnt[0] !== 1) $display("FAIL en_upd: got %0d want 1", upd_cnt[0]); else pass_cnt++;
  endtask

  task automatic test_reset_midburst();
    int n;
    do_reset();
    salt = 24'h555555;
    refresh = 2'b10; tick(1); refresh = '0;
    tick(10);
    chk_cnt++; if (param[1][0] !== {24'h555555, 8'h04}) $display("FAIL mr_setup: got %h want %h", param[1][0], {24'h555555, 8'h04}); else pass_cnt++;
    refresh = 2'b10; tick(1); refresh = '0;
    n = 0;
    while (!(bus.valid && bus.addr == 8'h06) && n < 20) begin tick(1); n++; end
    chk_cnt++; if (n >= 20) $display("FAIL mr_word2_wait: got %0d cycles want <20", n); else pass_cnt++;
    #2 rstn = 1'b0;
    #1;
    chk_cnt++; if (bus.valid !== 1'b0) $display("FAIL mr_valid: got %b want 0", bus.valid); else pass_cnt++;
    chk_cnt++; if (param !== '0) $display("FAIL mr_param: got %h want 0", param); else pass_cnt++;
    tick(1);
    rstn = 1'b1;
    clear_logs();
    tick(10);
    chk_cnt++; if (upd_cnt[1] !== 0 || upd_cnt[0] !== 0) $display("FAIL mr_no_upd: got %0d/%0d want 0/0", upd_cnt[0], upd_cnt[1]); else pass_cnt++;
    chk_cnt++; if (rise_cyc.size() !== 0) $display("FAIL mr_no_burst: got %0d want 0", rise_cyc.size()); else pass_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_periodic();
    test_ch1_burst();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_enable();
    test_reset_midburst();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
